tw_mult_6th: RTL

Twiddle-multiply stage for the 6th FFT stage. Sits between the stage-6 butterfly output stream and the stage-7 input. The block drives the stage-6 twiddle ROM (`tw_factor_for_6th`) read port with an index derived from an internal sample counter. It multiplies each complex sample by the returned W64^k = cos + j·sin, where the ROM stores sin as −sin θ in Q2.12. Results are rounded and saturated back to the data width, with a fixed latency and no backpressure.

---
 rtl/tw_mult_6th_pkg.sv | 16 +
 rtl/cmult_round_sat.sv | 104 ++++++++++
 rtl/tw_mult_6th.sv | 76 +++++++
 3 files changed

// File: rtl/tw_mult_6th_pkg.sv
// Shared constants for the stage-6 twiddle multiplier: Q2.12 scaling and
// saturation bounds for a given data width.
package tw_mult_6th_pkg;

  localparam int TW_FRAC  = 12;
  localparam int TW_ROUND = 1 << (TW_FRAC - 1);

  function automatic int sat_max(input int wl);
    return (1 << (wl - 1)) - 1;
  endfunction

  function automatic int sat_min(input int wl);
    return -(1 << (wl - 1));
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Two-stage complex multiply by a Q2.12 twiddle, round-half-up and saturate.
// A valid bit and tag ride alongside the data.
module cmult_round_sat
  import tw_mult_6th_pkg::*;
#(
  parameter int WL    = 16,
  parameter int TWL   = 14,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WL-1:0]    a,
  input  logic [WL-1:0]    b,
  input  logic [TWL-1:0]   c,
  input  logic [TWL-1:0]   s,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [WL-1:0]    out_re,
  output logic [WL-1:0]    out_im,
  output logic             ovf
);

  localparam int PW = WL + TWL;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(sat_max(WL));
  localparam logic signed [SW-1:0] MIN_V = SW'(sat_min(WL));
  localparam logic signed [SW-1:0] RND_V = SW'(TW_ROUND);

  logic signed [PW-1:0] a_x, b_x, c_x, s_x;
  logic signed [PW-1:0] p_ac, p_bs, p_as, p_bc;
  logic                 v1;
  logic [TAG_W-1:0]     t1;

  assign a_x = PW'($signed(a));
  assign b_x = PW'($signed(b));
  assign c_x = PW'($signed(c));
  assign s_x = PW'($signed(s));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      t1   <= '0;
      p_ac <= '0;
      p_bs <= '0;
      p_as <= '0;
      p_bc <= '0;
    end else begin
      v1 <= in_valid;
      t1 <= in_valid ? in_tag : '0;
      if (in_valid) begin
        p_ac <= a_x * c_x;
        p_bs <= b_x * s_x;
        p_as <= a_x * s_x;
        p_bc <= b_x * c_x;
      end
    end
  end

  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;
  logic [WL-1:0]        y_re, y_im;
  logic                 sat_re, sat_im;

  always_comb begin
    sum_re = SW'(p_ac) - SW'(p_bs);
    sum_im = SW'(p_as) + SW'(p_bc);
    rnd_re = (sum_re + RND_V) >>> TW_FRAC;
    rnd_im = (sum_im + RND_V) >>> TW_FRAC;
    sat_re = 1'b1;
    sat_im = 1'b1;
    if (rnd_re > MAX_V)      y_re = MAX_V[WL-1:0];
    else if (rnd_re < MIN_V) y_re = MIN_V[WL-1:0];
    else begin
      y_re   = rnd_re[WL-1:0];
      sat_re = 1'b0;
    end
    if (rnd_im > MAX_V)      y_im = MAX_V[WL-1:0];
    else if (rnd_im < MIN_V) y_im = MIN_V[WL-1:0];
    else begin
      y_im   = rnd_im[WL-1:0];
      sat_im = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= v1;
      out_tag   <= v1 ? t1 : '0;
      ovf       <= v1 && (sat_re || sat_im);
      if (v1) begin
        out_re <= y_re;
        out_im <= y_im;
      end
    end
  end

endmodule

// File: rtl/tw_mult_6th.sv
// Stage-6 FFT twiddle multiplier: sample counter, twiddle ROM addressing and
// input alignment to the ROM's one-cycle read latency.
module tw_mult_6th
  import tw_mult_6th_pkg::*;
#(
  parameter int stage_FFT      = 6,
  parameter int word_length    = 16,
  parameter int word_length_tw = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic [word_length-1:0]    in_re,
  input  logic [word_length-1:0]    in_im,
  output logic                      en_rd,
  output logic [stage_FFT-2:0]      rd_ptr_angle,
  input  logic [word_length_tw-1:0] cos_data,
  input  logic [word_length_tw-1:0] sin_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [word_length-1:0]    out_re,
  output logic [word_length-1:0]    out_im,
  output logic                      ovf
);

  localparam int IW = stage_FFT;

  logic [IW-1:0]          cnt, idx;
  logic                   v0, l0;
  logic [word_length-1:0] re0, im0;

  // First half of the frame is an identity pass through ROM entry 0.
  assign idx          = in_sop ? '0 : cnt;
  assign en_rd        = in_valid;
  assign rd_ptr_angle = (in_valid && idx[IW-1]) ? idx[IW-2:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      v0  <= 1'b0;
      l0  <= 1'b0;
      re0 <= '0;
      im0 <= '0;
    end else begin
      v0 <= in_valid;
      l0 <= in_valid && (idx == '1);
      if (in_valid) begin
        cnt <= idx + IW'(1);
        re0 <= in_re;
        im0 <= in_im;
      end
    end
  end

  cmult_round_sat #(
    .WL    (word_length),
    .TWL   (word_length_tw),
    .TAG_W (1)
  ) u_cmult (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v0),
    .in_tag    (l0),
    .a         (re0),
    .b         (im0),
    .c         (cos_data),
    .s         (sin_data),
    .out_valid (out_valid),
    .out_tag   (out_last),
    .out_re    (out_re),
    .out_im    (out_im),
    .ovf       (ovf)
  );

endmodule
